// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_rx_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_BIT_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Counter width for the bit timer; PERIOD is at least 2, so never below 1 bit.
    function automatic int timer_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_rx_bit_timer.sv
// Bit timer: tick fires FIRST edges after restart, then every PERIOD edges.
module serial_frame_rx_bit_timer
    import serial_frame_rx_pkg::*;
#(
    parameter int PERIOD = DEF_BIT_CYCLES,
    parameter int FIRST  = DEF_BIT_CYCLES / 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int            CW          = timer_width(PERIOD);
    localparam logic [CW-1:0] FIRST_LOAD  = CW'(FIRST - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(PERIOD - 1);
    localparam logic [CW-1:0] ONE_C       = CW'(1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // The counter is a countdown to zero; zero is the tick.
    always_comb begin
        count_next = count_reg;
        tick       = 1'b0;
        if (restart) begin
            count_next = FIRST_LOAD;
        end else if (count_reg == '0) begin
            tick       = 1'b1;
            count_next = PERIOD_LOAD;
        end else begin
            count_next = count_reg - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Idle-high serial frame receiver with a valid/ready holding register.
// Define SERIAL_FRAME_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
`ifdef SERIAL_FRAME_RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int               HALF     = BIT_CYCLES / 2;
    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    rx_state_e         state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              frame_err_reg, frame_err_next;
    logic              overrun_reg, overrun_next;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic              parity_bit_reg, parity_bit_next;
    logic              parity_err_reg, parity_err_next;
    logic              parity_ok;
`endif

    logic restart;
    logic tick;
    logic bit_we;
    logic good_frame;

    serial_frame_rx_bit_timer #(
        .PERIOD (BIT_CYCLES),
        .FIRST  (HALF)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Each data sample lands directly in its LSB-first slot.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
            assign shift_next[gi] = (bit_we && (idx_reg == IDX_W'(gi))) ? sin : shift_reg[gi];
        end
    endgenerate

`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_ok = (parity_bit_reg == ^shift_reg);
`endif

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        restart        = 1'b0;
        bit_we         = 1'b0;
        good_frame     = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif

        if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!sin) begin
                    state_next = START;
                    restart    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = sin ? IDLE : DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    bit_we = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        idx_next = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx_reg + IDX_ONE;
                    end
                end
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    parity_bit_next = sin;
                    state_next      = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    parity_err_next = !parity_ok;
`endif
                    if (sin) begin
                        state_next = IDLE;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        good_frame = parity_ok;
`else
                        good_frame = 1'b1;
`endif
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (sin) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A draining holder frees the slot on the same edge a new word arrives.
        if (good_frame) begin
            if (!valid_reg || out_ready) begin
                data_next  = shift_reg;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            idx_reg       <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            idx_reg       <= idx_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receiver end of a single-wire, idle-high serial frame link.
- Each frame is start bit 0, DATA_W data bits LSB-first, optional parity bit, then stop bit 1.
- The block samples the line at mid-bit, reassembles the word, and presents it on a valid/ready output with framing and overrun flags.
- It sits downstream of any single-bit serial driver in the test designs.
- Bit timing is a sub-module parameterised indirectly through a top-level localparam.

Parameters:
- DATA_W, 8, number of data bits per frame (1..32).
- BIT_CYCLES, 4, clock cycles per serial bit (even, >=2). Localparam HALF = BIT_CYCLES/2 is passed to the timer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- sin  input  1  serial line, idle high.
- out_data  output  DATA_W  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: frame completed while the holding register was full and not draining.

Behaviour:
- Interface (decided): one clock clk; reset rst_n is synchronous and active-low.
- Reset: on a clk edge with rst_n==0:
  - state=IDLE; shift register, bit index and timer cleared.
  - out_data=0, out_valid=0, frame_err=0, overrun=0.
  - A partial frame is discarded; reset dominates all other events.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- Edge e0 is the first edge where IDLE samples sin==0.
  - At e0: state goes to START and the timer restarts.
- START: at the edge e0+HALF, sin is sampled.
  - sin==0: go to DATA with bit index 0.
  - sin==1: false start, return to IDLE with no flags.
- DATA: every BIT_CYCLES edges after the mid-start sample, sin is shifted into bit[idx].
  - After bit DATA_W-1, go to PARITY or STOP.
- STOP: sampled BIT_CYCLES edges after the last data/parity sample.
  - sin==1: the frame is good; go to IDLE.
  - sin==0: frame_err pulses, the word is dropped, and the state goes to WAIT_IDLE.
- WAIT_IDLE: stay until sin==1, then go to IDLE. This blocks a held-low line from retriggering.
- IDLE can accept a new start on the edge after the STOP sample.
- Good-frame completion edge is ec = e0 + HALF + (DATA_W+1)*BIT_CYCLES. For defaults, ec = e0+38; with parity, add BIT_CYCLES.
- Holding register: on ec, out_data/out_valid update according to these cases.
  - out_valid==0: load, out_valid=1.
  - out_valid==1 && out_ready==1 in the same cycle: old word consumed, new word loaded, out_valid stays 1, no overrun.
  - out_valid==1 && out_ready==0: new word dropped, old word kept, overrun pulses.
- out_valid clears on the edge where out_valid && out_ready, unless a load occurs on that edge.
- out_data is stable while out_valid==1 && out_ready==0.
- Flags are registered one-cycle pulses; frame_err and overrun never assert in the same cycle.

Optional Feature:
- Macro SERIAL_FRAME_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA; an even-parity bit is expected.
  - Output port parity_err (1 bit, reset 0) pulses on the STOP edge when the parity sample mismatches XOR of the data.
  - A word with a parity mismatch is still dropped, with no load and no overrun.
  - All latencies grow by BIT_CYCLES.
- Undefined:
  - No PARITY state and no parity_err port; timings as above.

Decomposition:
- Package serial_frame_rx_pkg:
  - state enum type rx_state_e.
  - Default constants DEF_DATA_W=8, DEF_BIT_CYCLES=4.
  - Function to compute timer width as $clog2(BIT_CYCLES).
- Sub-module serial_frame_rx_bit_timer:
  - Parameters PERIOD (=BIT_CYCLES) and FIRST (=HALF), both passed from top localparams.
  - Inputs clk, rst_n, restart.
  - Output tick: first pulse FIRST edges after restart, then every PERIOD edges.
  - Counter width from the package function.

Test Plan:
- Basic receive, defaults: frame 0xA5 with out_ready=1 -> out_valid high on e0+38, out_data=0xA5, consumed next edge, no flags.
- False start: sin low for 1 cycle then high -> returns to IDLE, no out_valid, no flags; a following frame 0x3C is received correctly.
- Framing error: 0x5A with stop bit 0, line held low 10 cycles -> frame_err pulse at e0+38, no load, no retrigger until sin returns high.
- Overrun: out_ready=0, frames 0x11 then 0x22 -> out_data stays 0x11, overrun pulses at the second completion. Then out_ready=1 for one cycle -> out_valid=0.
- Simultaneous: 0x22 completes on the same edge out_ready=1 with 0x11 held -> 0x11 consumed, out_data=0x22, out_valid=1, no overrun.
- Reset mid-frame and parity:
  - rst_n=0 at the 5th data bit -> all outputs 0, next full frame 0x81 received cleanly.
  - With SERIAL_FRAME_RX_PARITY_EN, 0x07 with wrong parity bit 0 -> parity_err pulse at e0+42, no out_valid.
